// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST controller: FSM state encoding and default sizing.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 6;
  localparam int unsigned DEF_SETTLE = 1;

endpackage

// File: rtl/adder_bist_cmp.sv
// Golden (WIDTH+1)-bit add of the applied operands compared against the adder's response.
module adder_bist_cmp
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout,
  output logic             mismatch
);

  logic [WIDTH:0] golden;

  always_comb begin
    golden   = {1'b0, x} + {1'b0, y};
    // Case inequality so unknown bits on the response count as a mismatch.
    mismatch = ({dut_cout, dut_s} !== golden);
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Exhaustive {x,y} sweep generator and checker for the WIDTH-bit adder.
// Define ADDER_BIST_ERRLOG_EN to add the first-mismatch log outputs.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  input  logic [WIDTH-1:0]   dut_s,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH-1:0] pat_idx,
  output logic [2*WIDTH:0]   err_count
`ifdef ADDER_BIST_ERRLOG_EN
  ,
  output logic [2*WIDTH-1:0] first_err_idx,
  output logic               first_err_vld
`endif
);

  localparam int unsigned PAT_W = 2 * WIDTH;
  localparam int unsigned ERR_W = 2 * WIDTH + 1;
  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE - 1);

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             load;
  logic             step;
  logic             chk;
  logic             mismatch;

  assign x = pat_idx[PAT_W-1:WIDTH];
  assign y = pat_idx[WIDTH-1:0];

  adder_bist_cmp #(.WIDTH(WIDTH)) u_cmp (
    .x        (x),
    .y        (y),
    .dut_s    (dut_s),
    .dut_cout (dut_cout),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    chk       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = DRIVE;
          load      = 1'b1;
        end
      end
      DRIVE: begin
        if (abort)                 state_nxt = IDLE;
        else if (settle_cnt == '0) state_nxt = CHECK;
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          chk = 1'b1;
          if (pat_idx == '1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRIVE;
            step      = 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = DRIVE;
          load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy = (state == DRIVE) || (state == CHECK);
    done = (state == DONE);
    pass = done && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_idx    <= '0;
      err_count  <= '0;
      settle_cnt <= '0;
    end else if (load) begin
      pat_idx    <= '0;
      err_count  <= '0;
      settle_cnt <= SET_LOAD;
    end else begin
      if (state == DRIVE && !abort && settle_cnt != '0)
        settle_cnt <= settle_cnt - SET_W'(1);
      if (chk) begin
        if (mismatch && err_count != '1)
          err_count <= err_count + ERR_W'(1);
        if (step) begin
          pat_idx    <= pat_idx + PAT_W'(1);
          settle_cnt <= SET_LOAD;
        end
      end
    end
  end

`ifdef ADDER_BIST_ERRLOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (load) begin
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (chk && mismatch && !first_err_vld) begin
      first_err_idx <= pat_idx;
      first_err_vld <= 1'b1;
    end
  end
`else
  // No first-mismatch log in this build.
`endif

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl with a fault-injectable adder model and a done-scoreboard.
// Define ADDER_BIST_ERRLOG_EN to also check the first-mismatch log.
module tb_adder_bist_ctrl;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned NPAT   = 1 << (2 * WIDTH);
  localparam int unsigned SWEEP  = NPAT * (SETTLE + 1);

  typedef struct {
    int unsigned err;
    bit          pass;
    int unsigned start_edge;
    int unsigned first_idx;
    bit          first_vld;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   dut_s;
  logic               dut_cout;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2*WIDTH-1:0] pat_idx;
  logic [2*WIDTH:0]   err_count;
`ifdef ADDER_BIST_ERRLOG_EN
  logic [2*WIDTH-1:0] first_err_idx;
  logic               first_err_vld;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int          fault    = 0;   // 0 good adder, 1 S[0] stuck-at-0, 2 cout stuck-at-0
  logic        done_q   = 1'b0;
  exp_t        sb[$];

  adder_bist_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .y         (y),
    .dut_s     (dut_s),
    .dut_cout  (dut_cout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .pat_idx   (pat_idx),
    .err_count (err_count)
`ifdef ADDER_BIST_ERRLOG_EN
    ,
    .first_err_idx (first_err_idx),
    .first_err_vld (first_err_vld)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH:0] sum;
  always_comb begin
    sum      = {1'b0, x} + {1'b0, y};
    dut_s    = sum[WIDTH-1:0];
    dut_cout = sum[WIDTH];
    if (fault == 1) dut_s[0] = 1'b0;
    if (fault == 2) dut_cout = 1'b0;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising done retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    done_q <= done;
    if (rst_n && done && !done_q) begin
      if (sb.size() == 0) begin
        check("sb_entry_at_done", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("sweep_err_count", err_count, e.err);
        check("sweep_pass", pass, e.pass);
        check("sweep_latency", cyc - e.start_edge, SWEEP);
        check("sweep_final_idx", pat_idx, NPAT - 1);
        check("sweep_busy_low", busy, 0);
`ifdef ADDER_BIST_ERRLOG_EN
        check("first_err_vld", first_err_vld, e.first_vld);
        check("first_err_idx", first_err_idx, e.first_idx);
`endif
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input int unsigned err, input bit p,
                           input int unsigned fidx, input bit fvld);
    exp_t e;
    e.err        = err;
    e.pass       = p;
    e.start_edge = cyc + 1;
    e.first_idx  = fidx;
    e.first_vld  = fvld;
    sb.push_back(e);
    pulse_start();
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (!done && n < SWEEP + 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", done, 1);
    @(negedge clk);
  endtask

  task automatic wait_idx(input int unsigned target);
    int unsigned n = 0;
    while (pat_idx != target && n < SWEEP + 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx", pat_idx, target);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_pat_idx", pat_idx, 0);
    check("rst_err_count", err_count, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // abort in IDLE has no effect
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // 1: good adder
    fault = 0;
    run_sweep(0, 1'b1, 0, 1'b0);
    check("first_drive_busy", busy, 1);
    check("first_drive_idx", pat_idx, 0);
    wait_done();
    check("done_held", done, 1);

    // 2: S[0] stuck-at-0, restarted from DONE; odd sums fail -> half the space
    fault = 1;
    run_sweep(2048, 1'b0, 12'h001, 1'b1);
    wait_done();

    // 3: cout stuck-at-0; x+y>=64 fails, first at x=1,y=63
    fault = 2;
    run_sweep(2016, 1'b0, 12'h07F, 1'b1);
    wait_done();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_done", done, 0);
    check("done_abort_err_held", err_count, 2016);

    // 4: abort at pat_idx 100 with S[0] fault (50 odd sums below 100)
    fault = 1;
    pulse_start();
    wait_idx(100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_idx_held", pat_idx, 100);
    check("abort_err_held", err_count, 50);
    check("abort_x_held", x, 1);
    check("abort_y_held", y, 36);
    fault = 0;
    run_sweep(0, 1'b1, 0, 1'b0);
    check("restart_idx", pat_idx, 0);
    check("restart_err", err_count, 0);
    check("restart_busy", busy, 1);
    wait_done();

    // 5: start while busy ignored; start+abort together -> IDLE
    fault = 0;
    pulse_start();
    wait_idx(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_start_ignored_idx", pat_idx, 51);
    check("busy_start_ignored_busy", busy, 1);
    wait_idx(200);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_idx", pat_idx, 200);

    // 6: asynchronous reset mid-run
    fault = 2;
    pulse_start();
    wait_idx(2000);
    check("pre_rst_err_nonzero", err_count != 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_idx", pat_idx, 0);
    check("async_rst_err", err_count, 0);
    check("async_rst_x", x, 0);
`ifdef ADDER_BIST_ERRLOG_EN
    check("async_rst_first_vld", first_err_vld, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_idx", pat_idx, 0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
